// File: rtl/frame_ctrl_if.sv
// Host-link bus of frame_ctrl: UART byte side plus the fast serial command/return lines.
interface frame_ctrl_if;
    logic [7:0] data_in;
    logic       in;
    logic       rx;
    logic       busy;
    logic [7:0] status;
    logic [7:0] data_out;
    logic       out;
    logic       tx;

    modport master (
        output data_in, in, rx, busy,
        input  status, data_out, out, tx
    );

    modport slave (
        input  data_in, in, rx, busy,
        output status, data_out, out, tx
    );
endinterface

// File: rtl/frame_ctrl.sv
// frame_ctrl: loads a BYTES-byte command, serialises it on tx, captures a RESP_BYTES response
// from rx and drains it to the UART. Optional load/response timeouts: FRAME_CTRL_TIMEOUT_EN.
module frame_ctrl #(
    parameter int unsigned BYTES      = 6,
    parameter int unsigned RESP_BYTES = 2,
    parameter int unsigned TIMEOUT    = 1024
) (
    input logic         clk,
    input logic         Rst,
    frame_ctrl_if.slave bus
);
    localparam int unsigned FW  = BYTES * 8;
    localparam int unsigned RW  = RESP_BYTES * 8;
    localparam int unsigned PW  = $clog2(FW + 2);
    localparam int unsigned RCW = $clog2(RW + 1);

    localparam logic [PW-1:0]  P_LAST_BYTE = PW'(BYTES - 1);
    localparam logic [PW-1:0]  P_STOP      = PW'(FW + 1);
    localparam logic [RCW-1:0] R_LAST_BIT  = RCW'(RW - 1);
    localparam logic [RCW-1:0] R_LAST_BYTE = RCW'(RESP_BYTES - 1);

    if (BYTES < 1 || RESP_BYTES < 1 || TIMEOUT < 2) begin : g_param_check
        $error("frame_ctrl: BYTES and RESP_BYTES must be >= 1, TIMEOUT >= 2");
    end

    typedef enum logic [2:0] {
        LOAD,
        SEND,
        WAIT_RESP,
        RECV,
        DRAIN
    } state_t;

    state_t         state, state_n;
    logic [PW-1:0]  ptr, ptr_n, byte_idx;
    logic [RCW-1:0] rcnt, rcnt_n;
    logic [FW-1:0]  frame, frame_n;
    logic [RW-1:0]  resp, resp_n;
    logic [7:0]     status, status_n;
    logic [7:0]     data_out, data_out_n;
    logic           out, out_n;
    logic           tx, tx_n;
    logic           load_tmo;

`ifdef FRAME_CTRL_TIMEOUT_EN
    localparam int unsigned    TW      = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]  T_LIMIT = TW'(TIMEOUT);
    logic [TW-1:0] tcnt, tcnt_n, tcnt_inc;
    assign tcnt_inc = tcnt + 1'b1;
`endif

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state    <= LOAD;
            ptr      <= '0;
            rcnt     <= '0;
            frame    <= '0;
            resp     <= '0;
            status   <= 8'hAA;
            data_out <= '0;
            out      <= 1'b0;
            tx       <= 1'b1;
`ifdef FRAME_CTRL_TIMEOUT_EN
            tcnt     <= '0;
`endif
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            rcnt     <= rcnt_n;
            frame    <= frame_n;
            resp     <= resp_n;
            status   <= status_n;
            data_out <= data_out_n;
            out      <= out_n;
            tx       <= tx_n;
`ifdef FRAME_CTRL_TIMEOUT_EN
            tcnt     <= tcnt_n;
`endif
        end
    end

    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        rcnt_n     = rcnt;
        frame_n    = frame;
        resp_n     = resp;
        status_n   = status;
        data_out_n = data_out;
        out_n      = 1'b0;
        tx_n       = 1'b1;
        load_tmo   = 1'b0;
        byte_idx   = ptr;
`ifdef FRAME_CTRL_TIMEOUT_EN
        tcnt_n     = tcnt;
`endif

        case (state)
            LOAD: begin
`ifdef FRAME_CTRL_TIMEOUT_EN
                if (ptr != '0) begin
                    if (tcnt_inc == T_LIMIT) begin
                        load_tmo = 1'b1;
                        tcnt_n   = '0;
                    end else if (bus.in) begin
                        tcnt_n = '0;
                    end else begin
                        tcnt_n = tcnt_inc;
                    end
                end
`endif
                // A timeout in the same cycle as a byte discards the old partial frame first,
                // so the byte starts a new frame with only the timeout flag left standing.
                if (load_tmo) begin
                    ptr_n       = '0;
                    byte_idx    = '0;
                    status_n[1] = 1'b1;
                end
                if (bus.in) begin
                    if (byte_idx == '0) begin
                        status_n = {6'b0, load_tmo, 1'b0};
                    end
                    frame_n = FW'({bus.data_in, frame} >> 8);
                    if (byte_idx == P_LAST_BYTE) begin
                        state_n = SEND;
                        ptr_n   = '0;
                    end else begin
                        ptr_n = byte_idx + 1'b1;
                    end
                end
            end

            SEND: begin
                ptr_n = ptr + 1'b1;
                if (ptr == '0) begin
                    tx_n = 1'b0;
                end else if (ptr == P_STOP) begin
                    tx_n        = 1'b1;
                    status_n[0] = 1'b1;
                    ptr_n       = '0;
                    state_n     = WAIT_RESP;
                end else begin
                    tx_n    = frame[0];
                    frame_n = frame >> 1;
                end
            end

            WAIT_RESP: begin
                if (!bus.rx) begin
                    state_n = RECV;
`ifdef FRAME_CTRL_TIMEOUT_EN
                    tcnt_n  = '0;
                end else if (tcnt_inc == T_LIMIT) begin
                    status_n[2] = 1'b1;
                    tcnt_n      = '0;
                    state_n     = LOAD;
                end else begin
                    tcnt_n = tcnt_inc;
`endif
                end
            end

            RECV: begin
                resp_n = {bus.rx, resp[RW-1:1]};
                if (rcnt == R_LAST_BIT) begin
                    rcnt_n  = '0;
                    state_n = DRAIN;
                end else begin
                    rcnt_n = rcnt + 1'b1;
                end
            end

            DRAIN: begin
                if (!bus.busy) begin
                    out_n      = 1'b1;
                    data_out_n = resp[7:0];
                    resp_n     = resp >> 8;
                    if (rcnt == R_LAST_BYTE) begin
                        rcnt_n      = '0;
                        status_n[3] = 1'b1;
                        state_n     = LOAD;
                    end else begin
                        rcnt_n = rcnt + 1'b1;
                    end
                end
            end

            default: state_n = LOAD;
        endcase

        if (bus.in && state != LOAD) begin
            status_n[4] = 1'b1;
        end
    end

    assign bus.status   = status;
    assign bus.data_out = data_out;
    assign bus.out      = out;
    assign bus.tx       = tx;
endmodule

// File: tb/tb_frame_ctrl.sv
// Randomised self-checking bench for frame_ctrl; expected line bits and status come from a
// bit-queue / flag model built from the frame rules.
module tb_frame_ctrl;
    localparam int unsigned BYTES      = 6;
    localparam int unsigned RESP_BYTES = 2;
    localparam int unsigned TMO        = 16;
    localparam int unsigned FW         = BYTES * 8;

    typedef logic [7:0] byte_q_t [$];

    logic clk = 1'b0;
    logic Rst = 1'b1;

    frame_ctrl_if bus ();

    frame_ctrl #(
        .BYTES     (BYTES),
        .RESP_BYTES(RESP_BYTES),
        .TIMEOUT   (TMO)
    ) dut (
        .clk(clk),
        .Rst(Rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int unsigned vecs = 0;
    int unsigned errs = 0;
    logic [7:0]  st_exp;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic byte_q_t rand_bytes(input int n);
        byte_q_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    task automatic check_status(input string tag);
        vecs++;
        if (bus.status !== st_exp) begin
            errs++;
            $display("FAIL %s status: got %h expected %h", tag, bus.status, st_exp);
        end
    endtask

    // Pushes cmd[first..] over the UART side, then checks the whole line frame on tx.
    task automatic send_frame(input byte_q_t cmd, input int first, input int drop_cycle,
                              input string tag);
        bit          exp_bits [$];
        logic [7:0]  v;
        int unsigned gap;
        bit          dropped = 0;
        exp_bits.push_back(1'b0);
        foreach (cmd[i]) begin
            v = cmd[i];
            for (int b = 0; b < 8; b++) exp_bits.push_back(v[b]);
        end
        exp_bits.push_back(1'b1);

        for (int i = first; i < cmd.size(); i++) begin
            if (i == 0) st_exp = 8'h00;
            bus.data_in = cmd[i];
            bus.in      = 1'b1;
            tick();
            bus.in      = 1'b0;
            bus.data_in = 8'($urandom);
            if (i != cmd.size() - 1) begin
                gap = $urandom_range(0, 3);
                repeat (gap) tick();
            end
        end
        vecs++;
        if (bus.tx !== 1'b1) begin
            errs++;
            $display("FAIL %s tx_after_last_byte: got %b expected 1", tag, bus.tx);
        end
        for (int n = 0; n < int'(FW) + 2; n++) begin
            if (n == drop_cycle) begin
                bus.in      = 1'b1;
                bus.data_in = 8'h5A;
                dropped     = 1;
            end
            tick();
            bus.in = 1'b0;
            vecs++;
            if (bus.tx !== exp_bits[n]) begin
                errs++;
                $display("FAIL %s tx_bit %0d: got %b expected %b", tag, n, bus.tx, exp_bits[n]);
            end
        end
        st_exp = st_exp | 8'h01 | (dropped ? 8'h10 : 8'h00);
        check_status({tag, "_sent"});
    endtask

    // Returns a response on rx after `gap` idle cycles, then drains it under busy.
    task automatic recv_drain(input byte_q_t resp, input int gap, input int busy_cycles,
                              input string tag);
        logic [7:0] v;
        logic       b;
        int         got = 0;
        bus.rx = 1'b1;
        repeat (gap) tick();
        bus.rx = 1'b0;
        tick();
        foreach (resp[i]) begin
            v = resp[i];
            for (int k = 0; k < 8; k++) begin
                bus.rx = v[k];
                tick();
                vecs++;
                if (bus.out !== 1'b0) begin
                    errs++;
                    $display("FAIL %s out_during_capture: got %b expected 0", tag, bus.out);
                end
            end
        end
        bus.rx = 1'b1;
        for (int c = 0; c < 400 && got < int'(RESP_BYTES); c++) begin
            b = (c < busy_cycles) ? 1'b1 : ($urandom_range(0, 3) == 0);
            bus.busy = b;
            tick();
            vecs++;
            if (b) begin
                if (bus.out !== 1'b0) begin
                    errs++;
                    $display("FAIL %s out_while_busy: got %b expected 0", tag, bus.out);
                end
            end else begin
                if (bus.out !== 1'b1 || bus.data_out !== resp[got]) begin
                    errs++;
                    $display("FAIL %s drain_byte %0d: out=%b data_out=%h expected out=1 data_out=%h",
                             tag, got, bus.out, bus.data_out, resp[got]);
                end
                got++;
            end
        end
        bus.busy = 1'b0;
        if (got < int'(RESP_BYTES)) begin
            errs++;
            $display("FAIL %s drain_timeout: got %0d bytes expected %0d", tag, got, RESP_BYTES);
        end
        st_exp = st_exp | 8'h08;
        check_status({tag, "_delivered"});
        tick();
        vecs++;
        if (bus.out !== 1'b0) begin
            errs++;
            $display("FAIL %s extra_out: got %b expected 0", tag, bus.out);
        end
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        repeat (3) tick();
        st_exp = 8'hAA;
        check_status("reset");
        vecs += 3;
        if (bus.tx !== 1'b1) begin errs++; $display("FAIL reset tx: got %b expected 1", bus.tx); end
        if (bus.out !== 1'b0) begin errs++; $display("FAIL reset out: got %b expected 0", bus.out); end
        if (bus.data_out !== 8'h00) begin
            errs++;
            $display("FAIL reset data_out: got %h expected 00", bus.data_out);
        end
        Rst = 1'b0;
        tick();
        check_status("reset_release");
    endtask

    task automatic test_command_frame();
        byte_q_t cmd = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_frame(cmd, 0, -1, "cmd_fixed");
    endtask

    task automatic test_response_backpressure();
        byte_q_t r = '{8'hA5, 8'h3C};
        recv_drain(r, 0, 5, "resp_fixed");
        st_exp = 8'h09;
        check_status("resp_fixed_final");
    endtask

    task automatic test_random_frames();
        for (int t = 0; t < 5; t++) begin
            send_frame(rand_bytes(BYTES), 0, -1, "rand");
            recv_drain(rand_bytes(RESP_BYTES), $urandom_range(0, TMO - 4), $urandom_range(0, 4),
                       "rand");
        end
    endtask

    task automatic test_dropped_byte();
        send_frame(rand_bytes(BYTES), 0, 10, "drop");
        recv_drain(rand_bytes(RESP_BYTES), 1, 0, "drop");
    endtask

    task automatic test_load_timeout();
        byte_q_t cmd = rand_bytes(BYTES);
        st_exp = 8'h00;
        for (int i = 0; i < 3; i++) begin
            bus.data_in = cmd[i];
            bus.in      = 1'b1;
            tick();
            bus.in      = 1'b0;
        end
`ifdef FRAME_CTRL_TIMEOUT_EN
        for (int k = 1; k <= int'(TMO); k++) begin
            tick();
            vecs++;
            if (bus.tx !== 1'b1) begin
                errs++;
                $display("FAIL load_tmo tx_idle: got %b expected 1", bus.tx);
            end
            if (k == int'(TMO) - 1) check_status("load_tmo_before");
        end
        st_exp = st_exp | 8'h02;
        check_status("load_tmo_fired");
        cmd = rand_bytes(BYTES);
        send_frame(cmd, 0, -1, "after_load_tmo");
`else
        for (int k = 0; k < 10 * int'(TMO); k++) begin
            tick();
            vecs++;
            if (bus.tx !== 1'b1) begin
                errs++;
                $display("FAIL load_wait tx_idle: got %b expected 1", bus.tx);
            end
        end
        check_status("load_wait");
        send_frame(cmd, 3, -1, "load_resume");
`endif
        recv_drain(rand_bytes(RESP_BYTES), 0, 2, "load_tmo_resp");
    endtask

    task automatic test_resp_timeout();
        send_frame(rand_bytes(BYTES), 0, -1, "resp_tmo");
        bus.rx = 1'b1;
`ifdef FRAME_CTRL_TIMEOUT_EN
        for (int k = 1; k <= int'(TMO); k++) begin
            tick();
            if (k == int'(TMO) - 1) check_status("resp_tmo_before");
        end
        st_exp = st_exp | 8'h04;
        check_status("resp_tmo_fired");
        send_frame(rand_bytes(BYTES), 0, -1, "after_resp_tmo");
        recv_drain(rand_bytes(RESP_BYTES), 2, 1, "after_resp_tmo");
`else
        repeat (10 * TMO) tick();
        check_status("resp_wait");
        vecs++;
        if (bus.out !== 1'b0) begin
            errs++;
            $display("FAIL resp_wait out: got %b expected 0", bus.out);
        end
        recv_drain(rand_bytes(RESP_BYTES), 0, 3, "resp_late");
`endif
    endtask

    task automatic test_midframe_reset();
        byte_q_t     cmd = rand_bytes(BYTES);
        int unsigned into;
        foreach (cmd[i]) begin
            bus.data_in = cmd[i];
            bus.in      = 1'b1;
            tick();
            bus.in      = 1'b0;
        end
        into = $urandom_range(2, 20);
        repeat (into) tick();
        Rst = 1'b1;
        #2;
        st_exp = 8'hAA;
        check_status("midreset");
        vecs += 2;
        if (bus.tx !== 1'b1) begin errs++; $display("FAIL midreset tx: got %b expected 1", bus.tx); end
        if (bus.out !== 1'b0) begin errs++; $display("FAIL midreset out: got %b expected 0", bus.out); end
        Rst = 1'b0;
        tick();
        check_status("midreset_release");
        send_frame(rand_bytes(BYTES), 0, -1, "after_reset");
        recv_drain(rand_bytes(RESP_BYTES), 0, 0, "after_reset");
    endtask

    initial begin
        bus.data_in = 8'h00;
        bus.in      = 1'b0;
        bus.rx      = 1'b1;
        bus.busy    = 1'b0;
        test_reset();
        test_command_frame();
        test_response_backpressure();
        test_random_frames();
        test_dropped_byte();
        test_load_timeout();
        test_resp_timeout();
        test_midframe_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
